// File: rtl/wb_pkg.sv
// wb_pkg: shared constants and types for the writeback arbiter (wb_arbiter, wb_fifo).
package wb_pkg;

   localparam int XLEN_DEF   = 32;
   localparam int REG_ADDR_W = 5;
   localparam int NUM_REGS   = 1 << REG_ADDR_W;

   // Buffered LSU result; a dead entry still occupies its slot until popped.
   typedef struct packed {
      logic                  live;
      logic [REG_ADDR_W-1:0] rd;
      logic [XLEN_DEF-1:0]   data;
   } wb_entry_t;

   typedef enum logic [1:0] {
      WB_NONE,
      WB_ALU,
      WB_LSU_FIFO,
      WB_LSU_BYPASS
   } wb_src_e;

endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: circular buffer of LSU writeback entries with kill-by-rd and a live-entry search
// that feeds the busy scoreboard and the forwarding lookup.
module wb_fifo
   import wb_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  push_i,
   input  wb_entry_t             push_entry_i,
   input  logic                  pop_i,
   input  logic                  kill_a_i,
   input  logic [REG_ADDR_W-1:0] kill_a_rd_i,
   input  logic                  kill_b_i,
   input  logic [REG_ADDR_W-1:0] kill_b_rd_i,
   output wb_entry_t             head_o,
   output logic                  empty_o,
   output logic                  full_o,
   output logic [NUM_REGS-1:0]   busy_o,
   input  logic [REG_ADDR_W-1:0] match_rd_i,
   output logic                  match_hit_o,
   output logic [XLEN_DEF-1:0]   match_data_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
   localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
   localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);

   wb_entry_t        mem_q [DEPTH];
   logic [PTR_W-1:0] head_q;
   logic [PTR_W-1:0] tail_q;
   logic [PTR_W:0]   count_q;
   logic             push_ok;
   logic             pop_ok;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == CNT_FULL);
   assign head_o  = mem_q[head_q];
   assign push_ok = push_i && !full_o;
   assign pop_ok  = pop_i && !empty_o;

   // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
   // NOTE: only the live bits and pointers are reset; rd/data are don't-care while an entry is not live.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i].live <= 1'b0;
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if ((kill_a_i && mem_q[i].rd == kill_a_rd_i) ||
                (kill_b_i && mem_q[i].rd == kill_b_rd_i)) begin
               mem_q[i].live <= 1'b0;
            end
         end
         if (pop_ok) begin
            mem_q[head_q].live <= 1'b0;
            head_q             <= head_q + PTR_ONE;
         end
         // The new entry is younger than every kill this cycle, so its write comes last.
         if (push_ok) begin
            mem_q[tail_q] <= push_entry_i;
            tail_q        <= tail_q + PTR_ONE;
         end
         if (push_ok && !pop_ok) begin
            count_q <= count_q + CNT_ONE;
         end else if (pop_ok && !push_ok) begin
            count_q <= count_q - CNT_ONE;
         end
      end
   end

   // NOTE: every output of this block gets a default first, so no latch can be inferred.
   always_comb begin
      busy_o       = '0;
      match_hit_o  = 1'b0;
      match_data_o = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (mem_q[i].live) begin
            busy_o[mem_q[i].rd] = 1'b1;
            if (mem_q[i].rd == match_rd_i) begin
               match_hit_o  = 1'b1;
               match_data_o = mem_q[i].data;
            end
         end
      end
      busy_o[0] = 1'b0;
   end

endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: merges the ALU and LSU writeback streams onto the register-file write port.
// Build option: define WB_FWD_EN to enable the forwarding lookup; XLEN must not exceed XLEN_DEF.
module wb_arbiter
   import wb_pkg::*;
#(
   parameter int XLEN  = XLEN_DEF,
   parameter int DEPTH = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  alu_valid_i,
   input  logic [REG_ADDR_W-1:0] alu_rd_i,
   input  logic [XLEN-1:0]       alu_data_i,
   input  logic                  lsu_valid_i,
   output logic                  lsu_ready_o,
   input  logic [REG_ADDR_W-1:0] lsu_rd_i,
   input  logic [XLEN-1:0]       lsu_data_i,
   output logic [XLEN-1:0]       dataW_o,
   output logic [REG_ADDR_W-1:0] rsW_o,
   output logic                  RegWEn_o,
   output logic [NUM_REGS-1:0]   busy_o,
   input  logic [REG_ADDR_W-1:0] fwd_rs_i,
   output logic                  fwd_hit_o,
   output logic [XLEN-1:0]       fwd_data_o
);

   wb_entry_t             head;
   wb_entry_t             push_entry;
   logic                  fifo_empty;
   logic                  fifo_full;
   logic                  fifo_hit;
   logic [XLEN_DEF-1:0]   fifo_hit_data;
   logic [REG_ADDR_W-1:0] lookup_rd;
   logic                  alu_go;
   logic                  lsu_xfer;
   logic                  lsu_keep;
   logic                  pop;
   logic                  push;
   wb_src_e               src;

   logic                  wen_q,  wen_d;
   logic [REG_ADDR_W-1:0] rd_q,   rd_d;
   logic [XLEN-1:0]       data_q, data_d;

   assign lsu_ready_o = !rst_i && !fifo_full;
   assign alu_go      = alu_valid_i && (alu_rd_i != '0);
   assign lsu_xfer    = lsu_valid_i && lsu_ready_o;
   assign lsu_keep    = lsu_xfer && (lsu_rd_i != '0);

   // A dead head still claims the slot: it is popped and nothing is written.
   always_comb begin
      src = WB_NONE;
      if (alu_go) begin
         src = WB_ALU;
      end else if (!fifo_empty) begin
         src = head.live ? WB_LSU_FIFO : WB_NONE;
      end else if (lsu_keep) begin
         src = WB_LSU_BYPASS;
      end
   end

   assign pop        = !alu_go && !fifo_empty;
   assign push       = lsu_keep && (src != WB_LSU_BYPASS);
   assign push_entry = '{live: 1'b1, rd: lsu_rd_i, data: XLEN_DEF'(lsu_data_i)};

   wb_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .push_i       (push),
      .push_entry_i (push_entry),
      .pop_i        (pop),
      .kill_a_i     (alu_go),
      .kill_a_rd_i  (alu_rd_i),
      .kill_b_i     (lsu_keep),
      .kill_b_rd_i  (lsu_rd_i),
      .head_o       (head),
      .empty_o      (fifo_empty),
      .full_o       (fifo_full),
      .busy_o       (busy_o),
      .match_rd_i   (lookup_rd),
      .match_hit_o  (fifo_hit),
      .match_data_o (fifo_hit_data)
   );

   always_comb begin
      wen_d  = 1'b1;
      rd_d   = rd_q;
      data_d = data_q;
      case (src)
         WB_ALU: begin
            rd_d   = alu_rd_i;
            data_d = alu_data_i;
         end
         WB_LSU_FIFO: begin
            rd_d   = head.rd;
            data_d = XLEN'(head.data);
         end
         WB_LSU_BYPASS: begin
            rd_d   = lsu_rd_i;
            data_d = lsu_data_i;
         end
         default: wen_d = 1'b0;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wen_q  <= 1'b0;
         rd_q   <= '0;
         data_q <= '0;
      end else begin
         wen_q  <= wen_d;
         rd_q   <= rd_d;
         data_q <= data_d;
      end
   end

   assign RegWEn_o = wen_q;
   assign rsW_o    = rd_q;
   assign dataW_o  = data_q;

`ifdef WB_FWD_EN
   assign lookup_rd = fwd_rs_i;

   // A buffered write is younger than the one in the output stage, so it wins.
   always_comb begin
      fwd_hit_o  = 1'b0;
      fwd_data_o = '0;
      if (fwd_rs_i != '0) begin
         if (fifo_hit) begin
            fwd_hit_o  = 1'b1;
            fwd_data_o = XLEN'(fifo_hit_data);
         end else if (wen_q && (rd_q == fwd_rs_i)) begin
            fwd_hit_o  = 1'b1;
            fwd_data_o = data_q;
         end
      end
   end
`else
   logic unused_fwd;

   assign lookup_rd  = '0;
   assign unused_fwd = ^{fwd_rs_i, fifo_hit, fifo_hit_data};
   assign fwd_hit_o  = 1'b0;
   assign fwd_data_o = '0;
`endif

endmodule
